hack_pc_jump: RTL and testbench

- Program-counter stage of the Hack CPU.
- Consumes the ALU status flags (zr, ng) and the jump field of the current C-instruction, then selects the next instruction address: jump target from the A register, PC+1, or hold.
- Detects the canonical Hack termination loop and freezes in a HALTED state until reset.
- Sits directly downstream of the ALU datapath (not16 and related gates) and upstream of instruction ROM addressing.

---
 rtl/hack_pc_jump.sv | 92 +++++++++
 tb/tb_hack_pc_jump.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/hack_pc_jump.sv
// Program-counter stage of the Hack CPU.
// Picks the next instruction address from the jump target, PC+1 or hold, and
// freezes in a HALTED state when the canonical termination loop is detected.
module hack_pc_jump #(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VEC   = '0,
  parameter bit               HALT_DETECT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             is_c,
  input  logic [2:0]       jmp,
  input  logic             zr,
  input  logic             ng,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic             jumped,
  output logic             halted
);

  typedef enum logic [0:0] {
    StRun,
    StHalted
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             jumped_q, jumped_d;

  logic             take;
  logic             halt_hit;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_dec;

  // Jump decision and termination-loop detection.
  always_comb begin
    pc_inc = pc_q + WIDTH'(1);
    pc_dec = pc_q - WIDTH'(1);
    take   = is_c & ((jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr));
    // Only an unconditional jump to self or to pc-1 ("(END) @END; 0;JMP") counts.
    halt_hit = HALT_DETECT && is_c && (jmp == 3'b111) &&
               ((target == pc_q) || (target == pc_dec));
  end

  // Next-state selection; HALTED and stalls hold everything.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    jumped_d = jumped_q;
    unique case (state_q)
      StRun: begin
        if (en) begin
          if (take) begin
            pc_d     = target;
            jumped_d = 1'b1;
            if (halt_hit) begin
              state_d = StHalted;
            end
          end else begin
            pc_d     = pc_inc;
            jumped_d = 1'b0;
          end
        end
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StRun;
      pc_q     <= RESET_VEC;
      jumped_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      jumped_q <= jumped_d;
    end
  end

  assign pc     = pc_q;
  assign jumped = jumped_q;
  assign halted = (state_q == StHalted);

endmodule

// File: tb/tb_hack_pc_jump.sv
// Scoreboard bench for hack_pc_jump: the driver pushes hand-computed
// expectations, the monitor pops and compares one per clock after the edge.
module tb_hack_pc_jump;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        is_c = 1'b0;
  logic [2:0]  jmp = 3'b000;
  logic        zr = 1'b0;
  logic        ng = 1'b0;
  logic [15:0] target = 16'h0000;

  logic [15:0] pc_a, pc_b;
  logic        jumped_a, jumped_b, halted_a, halted_b;

  hack_pc_jump #(.WIDTH(16), .RESET_VEC(16'h0000), .HALT_DETECT(1'b1)) u_dut_a (
    .clk(clk), .reset(reset), .en(en), .is_c(is_c), .jmp(jmp), .zr(zr), .ng(ng),
    .target(target), .pc(pc_a), .jumped(jumped_a), .halted(halted_a)
  );

  hack_pc_jump #(.WIDTH(16), .RESET_VEC(16'h0000), .HALT_DETECT(1'b0)) u_dut_b (
    .clk(clk), .reset(reset), .en(en), .is_c(is_c), .jmp(jmp), .zr(zr), .ng(ng),
    .target(target), .pc(pc_b), .jumped(jumped_b), .halted(halted_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic        j;
    logic        h;
    logic        chk_b;
    logic [15:0] pc_b;
    logic        j_b;
    logic        h_b;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  bit   b_sync   = 1'b1;  // instance without halt detect tracks the same expectation

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: one registered result per clock edge, compared against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".pc"}, pc_a, e.pc);
        check({e.name, ".jumped"}, {15'd0, jumped_a}, {15'd0, e.j});
        check({e.name, ".halted"}, {15'd0, halted_a}, {15'd0, e.h});
        if (e.chk_b) begin
          check({e.name, ".b.pc"}, pc_b, e.pc_b);
          check({e.name, ".b.jumped"}, {15'd0, jumped_b}, {15'd0, e.j_b});
          check({e.name, ".b.halted"}, {15'd0, halted_b}, {15'd0, e.h_b});
        end
      end
    end
  end

  task automatic drive(input logic r, input logic e_n, input logic c, input logic [2:0] j,
                       input logic z, input logic n, input logic [15:0] t);
    @(negedge clk);
    reset  = r;
    en     = e_n;
    is_c   = c;
    jmp    = j;
    zr     = z;
    ng     = n;
    target = t;
  endtask

  task automatic step(input logic r, input logic e_n, input logic c, input logic [2:0] j,
                      input logic z, input logic n, input logic [15:0] t,
                      input logic [15:0] ep, input logic ej, input logic eh, input string nm);
    exp_t x;
    drive(r, e_n, c, j, z, n, t);
    x = '{pc: ep, j: ej, h: eh, chk_b: b_sync, pc_b: ep, j_b: ej, h_b: 1'b0, name: nm};
    sb.push_back(x);
  endtask

  task automatic step_b(input logic r, input logic e_n, input logic c, input logic [2:0] j,
                        input logic z, input logic n, input logic [15:0] t,
                        input logic [15:0] ep, input logic ej, input logic eh,
                        input logic [15:0] ep_b, input logic ej_b, input string nm);
    exp_t x;
    drive(r, e_n, c, j, z, n, t);
    x = '{pc: ep, j: ej, h: eh, chk_b: 1'b1, pc_b: ep_b, j_b: ej_b, h_b: 1'b0, name: nm};
    sb.push_back(x);
  endtask

  // Taken-jump masks, bit i = jmp value i, for (zr,ng) = (1,0), (0,1), (0,0).
  logic [7:0] masks [3] = '{8'b1100_1100, 8'b1111_0000, 8'b1010_1010};
  logic       zrs   [3] = '{1'b1, 1'b0, 1'b0};
  logic       ngs   [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    logic [7:0] m;
    bit         tk;
    int         budget;

    // Reset and sequential count.
    step(1, 0, 0, 3'b000, 0, 0, 16'h0000, 16'h0000, 0, 0, "reset");
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 0, 3'b000, 0, 0, 16'h0000, 16'(i), 0, 0, $sformatf("count%0d", i));
    end

    // Jump-condition table from pc=0010; reload via a JGT jump that never halts.
    for (int f = 0; f < 3; f++) begin
      m = masks[f];
      for (int jj = 0; jj < 8; jj++) begin
        tk = m[jj];
        step(0, 1, 1, 3'b001, 0, 0, 16'h0010, 16'h0010, 1, 0, "reload");
        step(0, 1, 1, 3'(jj), zrs[f], ngs[f], 16'h0100,
             tk ? 16'h0100 : 16'h0011, tk, 0, $sformatf("jt_f%0d_j%0d", f, jj));
      end
    end
    step(0, 1, 1, 3'b001, 0, 0, 16'h0010, 16'h0010, 1, 0, "reload");
    step(0, 1, 0, 3'b111, 1, 0, 16'h0100, 16'h0011, 0, 0, "a_instr_jmp111");

    // Stall and wrap.
    step(0, 1, 1, 3'b001, 0, 0, 16'hFFFE, 16'hFFFE, 1, 0, "load_fffe");
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 3'b111, 0, 1, 16'h1234, 16'hFFFE, 1, 0, $sformatf("stall%0d", i));
    end
    step(0, 1, 0, 3'b000, 0, 0, 16'h0000, 16'hFFFF, 0, 0, "inc_ffff");
    step(0, 1, 0, 3'b000, 0, 0, 16'h0000, 16'h0000, 0, 0, "wrap_0000");

    // Halt idiom: jump to pc-1.
    step(0, 1, 1, 3'b001, 0, 0, 16'h0021, 16'h0021, 1, 0, "load_0021");
    step_b(0, 1, 1, 3'b111, 0, 0, 16'h0020, 16'h0020, 1, 1, 16'h0020, 1, "halt_pcm1");
    b_sync = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
           16'h0020, 1, 1, $sformatf("halted_hold%0d", i));
    end
    b_sync = 1'b1;
    step(1, 1, 0, 3'b000, 0, 0, 16'h0000, 16'h0000, 0, 0, "reset_from_halt");

    // Conditional self-jump never halts; unconditional self-jump halts only with detect.
    step(0, 1, 1, 3'b001, 0, 0, 16'h0030, 16'h0030, 1, 0, "load_0030");
    step(0, 1, 1, 3'b010, 1, 0, 16'h0030, 16'h0030, 1, 0, "cond_self_jump");
    step_b(0, 1, 1, 3'b111, 0, 0, 16'h0030, 16'h0030, 1, 1, 16'h0030, 1, "uncond_self_jump");
    step_b(0, 1, 0, 3'b000, 0, 0, 16'h0000, 16'h0030, 1, 1, 16'h0031, 0, "after_self_jump");

    // Reset priority over a taken jump while HALTED / running.
    step(1, 1, 1, 3'b111, 0, 0, 16'h0200, 16'h0000, 0, 0, "reset_priority");
    step(0, 1, 1, 3'b100, 0, 1, 16'h0200, 16'h0200, 1, 0, "jlt_after_reset");
    step(1, 1, 1, 3'b111, 0, 0, 16'h0200, 16'h0000, 0, 0, "reset_mid_run");

    // Drain the scoreboard with a bounded wait.
    drive(0, 0, 0, 3'b000, 0, 0, 16'h0000);
    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    check("scoreboard_drain", 16'(sb.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
